// File: rtl/keypad_entry_if.sv
// Keypad entry interface: scanner inputs (key code + hit strobe) and the
// committed entry/value/event outputs of keypad_entry.
interface keypad_entry_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int BW = 4 * NUM_DIGITS;

  logic [4:0]    digito;
  logic          cambio_digito;
  logic [BW-1:0] entry_bcd;
  logic [CW-1:0] entry_count;
  logic [BW-1:0] value_bcd;
  logic [CW-1:0] value_count;
  logic          value_valid;
  logic [1:0]    letter;
  logic          letter_valid;
  logic          cleared;
  logic          overflow;

  // Scanner / environment side
  modport master (
    output digito, cambio_digito,
    input  entry_bcd, entry_count, value_bcd, value_count, value_valid,
           letter, letter_valid, cleared, overflow
  );

  // keypad_entry side
  modport slave (
    input  digito, cambio_digito,
    output entry_bcd, entry_count, value_bcd, value_count, value_valid,
           letter, letter_valid, cleared, overflow
  );
endinterface

// File: rtl/keypad_entry.sv
// keypad_entry: debounces scanner hits, detects release and commits one action
// per key press (BCD digit entry, '#' enter, '*' clear, A-D letters).
// Optional feature: define KEYPAD_BACKSPACE_EN to make 'D' a backspace key.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no key down; first valid strobe starts debouncing
//   DEBOUNCE | counting consecutive same-code strobes toward PRESS_HITS
//   HELD     | press committed; waiting for RELEASE_TICKS strobe-free cycles
module keypad_entry #(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESS_HITS    = 3,
  parameter int RELEASE_TICKS = 8
) (
  input logic          clk,
  input logic          rst_n,
  keypad_entry_if.slave bus
);
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int GW = $clog2(RELEASE_TICKS + 1);
  localparam int HW = $clog2(PRESS_HITS + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [HW-1:0] hits_q, hits_d;
  logic [GW-1:0] gap_q;
  logic          commit_en;
  logic          valid_strobe;
  logic          released;

  logic [BW-1:0] entry_q;
  logic [CW-1:0] count_q;
  logic [BW-1:0] value_q;
  logic [CW-1:0] vcount_q;
  logic          value_valid_q;
  logic [1:0]    letter_q;
  logic          letter_valid_q;
  logic          cleared_q;
  logic          overflow_q;

  // Codes 16 (none) and 17 (bad) are not key hits.
  assign valid_strobe = bus.cambio_digito && (bus.digito < 5'd16);
  assign released     = (gap_q == GW'(RELEASE_TICKS));

  // Strobe-free cycle counter, saturating at the release threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            gap_q <= '0;
    else if (valid_strobe) gap_q <= '0;
    else if (!released)    gap_q <= gap_q + GW'(1);
  end

  // FSM state, candidate code and hit count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      hits_q  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      hits_q  <= hits_d;
    end
  end

  // Next-state logic; commit fires on the PRESS_HITS-th matching strobe.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    hits_d    = hits_q;
    commit_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_strobe) begin
          state_d = DEBOUNCE;
          cand_d  = bus.digito[3:0];
          hits_d  = HW'(1);
        end
      end
      DEBOUNCE: begin
        if (valid_strobe) begin
          if (bus.digito[3:0] == cand_q) begin
            if (hits_q + HW'(1) == HW'(PRESS_HITS)) begin
              commit_en = 1'b1;
              state_d   = HELD;
              hits_d    = '0;
            end else begin
              hits_d = hits_q + HW'(1);
            end
          end else begin
            cand_d = bus.digito[3:0];
            hits_d = HW'(1);
          end
        end else if (released) begin
          state_d = IDLE;
          hits_d  = '0;
        end
      end
      HELD: begin
        if (!valid_strobe && released) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Committed-action registers; pulse outputs default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q        <= '0;
      count_q        <= '0;
      value_q        <= '0;
      vcount_q       <= '0;
      value_valid_q  <= 1'b0;
      letter_q       <= '0;
      letter_valid_q <= 1'b0;
      cleared_q      <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      value_valid_q  <= 1'b0;
      letter_valid_q <= 1'b0;
      cleared_q      <= 1'b0;
      if (commit_en) begin
        if (bus.digito[3:0] <= 4'd9) begin
          if (count_q < CW'(NUM_DIGITS)) begin
            entry_q <= {entry_q[BW-5:0], bus.digito[3:0]};
            count_q <= count_q + CW'(1);
          end else begin
            overflow_q <= 1'b1;
          end
        end else if (bus.digito[3:0] == 4'hE) begin
          value_q       <= entry_q;
          vcount_q      <= count_q;
          value_valid_q <= 1'b1;
          entry_q       <= '0;
          count_q       <= '0;
          overflow_q    <= 1'b0;
        end else if (bus.digito[3:0] == 4'hF) begin
          entry_q    <= '0;
          count_q    <= '0;
          overflow_q <= 1'b0;
          cleared_q  <= 1'b1;
`ifdef KEYPAD_BACKSPACE_EN
        end else if (bus.digito[3:0] == 4'hD) begin
          overflow_q <= 1'b0;
          if (count_q != '0) begin
            entry_q <= {4'h0, entry_q[BW-1:4]};
            count_q <= count_q - CW'(1);
          end
`endif
        end else begin
          letter_q       <= bus.digito[1:0] + 2'd2;
          letter_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.entry_bcd    = entry_q;
  assign bus.entry_count  = count_q;
  assign bus.value_bcd    = value_q;
  assign bus.value_count  = vcount_q;
  assign bus.value_valid  = value_valid_q;
  assign bus.letter       = letter_q;
  assign bus.letter_valid = letter_valid_q;
  assign bus.cleared      = cleared_q;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_keypad_entry.sv
// Directed testbench for keypad_entry: held key = one strobe every 4 cycles.
module tb_keypad_entry;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   n_vv = 0;
  int   n_lv = 0;
  int   n_cl = 0;
  int   b_vv, b_lv, b_cl;

  keypad_entry_if #(.NUM_DIGITS(4)) bus();

  keypad_entry #(.NUM_DIGITS(4), .PRESS_HITS(3), .RELEASE_TICKS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Count cycles each pulse output is high.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.value_valid)  n_vv <= n_vv + 1;
      if (bus.letter_valid) n_lv <= n_lv + 1;
      if (bus.cleared)      n_cl <= n_cl + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [4:0] code);
    bus.digito = code;
    bus.cambio_digito = 1'b1;
    tick();
    bus.cambio_digito = 1'b0;
    bus.digito = 5'd16;
  endtask

  task automatic hold(input logic [4:0] code, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (i % 4 == 0) strobe(code);
      else tick();
    end
  endtask

  task automatic press(input logic [4:0] code);
    hold(code, 20);
    idle(20);
  endtask

  task automatic snap();
    b_vv = n_vv;
    b_lv = n_lv;
    b_cl = n_cl;
  endtask

  initial begin
    bus.digito = 5'd16;
    bus.cambio_digito = 1'b0;
    idle(3);
    check("rst_entry", 32'(bus.entry_bcd), 32'h0);
    check("rst_count", 32'(bus.entry_count), 32'h0);
    check("rst_value", 32'(bus.value_valid), 32'h0);
    check("rst_ovf", 32'(bus.overflow), 32'h0);
    rst_n = 1'b1;
    idle(12);

    // 1: digits 1,2,3
    snap();
    press(5'd1); press(5'd2); press(5'd3);
    check("t1_entry", 32'(bus.entry_bcd), 32'h0123);
    check("t1_count", 32'(bus.entry_count), 32'd3);

    // 2: '#' with exact pulse timing
    strobe(5'hE); idle(3); strobe(5'hE); idle(3);
    check("t2_vv_early", 32'(bus.value_valid), 32'h0);
    strobe(5'hE);
    check("t2_vv_pulse", 32'(bus.value_valid), 32'h1);
    check("t2_value", 32'(bus.value_bcd), 32'h0123);
    check("t2_vcount", 32'(bus.value_count), 32'd3);
    check("t2_entry", 32'(bus.entry_bcd), 32'h0);
    check("t2_count", 32'(bus.entry_count), 32'd0);
    tick();
    check("t2_vv_drop", 32'(bus.value_valid), 32'h0);
    idle(2); hold(5'hE, 12); idle(20);
    check("t2_vv_once", 32'(n_vv - b_vv), 32'd1);

    // 3: overflow then '*'
    press(5'd1); press(5'd2); press(5'd3); press(5'd4); press(5'd5);
    check("t3_entry", 32'(bus.entry_bcd), 32'h1234);
    check("t3_count", 32'(bus.entry_count), 32'd4);
    check("t3_ovf", 32'(bus.overflow), 32'h1);
    snap();
    press(5'hF);
    check("t3_clr_entry", 32'(bus.entry_bcd), 32'h0);
    check("t3_clr_ovf", 32'(bus.overflow), 32'h0);
    check("t3_cleared", 32'(n_cl - b_cl), 32'd1);
    check("t3_value_kept", 32'(bus.value_bcd), 32'h0123);

    // empty '#' still pulses
    snap();
    press(5'hE);
    check("t3_empty_vv", 32'(n_vv - b_vv), 32'd1);
    check("t3_empty_vcnt", 32'(bus.value_count), 32'd0);

    // 4: debounce rejects
    strobe(5'd7); idle(12);
    check("t4_single", 32'(bus.entry_count), 32'd0);
    strobe(5'd7); idle(3); strobe(5'd8); idle(3);
    strobe(5'd7); idle(3); strobe(5'd8); idle(20);
    check("t4_alt", 32'(bus.entry_count), 32'd0);
    strobe(5'd7); idle(3); strobe(5'd7); idle(3); strobe(5'd7); idle(20);
    check("t4_digit", 32'(bus.entry_bcd[3:0]), 32'h7);
    check("t4_count", 32'(bus.entry_count), 32'd1);

    // 5: long hold, then 'B'
    hold(5'd5, 400); idle(20);
    check("t5_hold", 32'(bus.entry_bcd), 32'h0075);
    snap();
    press(5'hB);
    check("t5_letter", 32'(bus.letter), 32'd1);
    check("t5_lv", 32'(n_lv - b_lv), 32'd1);
    check("t5_entry", 32'(bus.entry_bcd), 32'h0075);

    // 6: reset in DEBOUNCE with hits=2
    strobe(5'd3); idle(3); strobe(5'd3); idle(1);
    rst_n = 1'b0;
    #1;
    check("t6_entry", 32'(bus.entry_bcd), 32'h0);
    check("t6_count", 32'(bus.entry_count), 32'd0);
    check("t6_letter", 32'(bus.letter), 32'd0);
    check("t6_value", 32'(bus.value_bcd), 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    strobe(5'd3); idle(3);
    check("t6_no_commit", 32'(bus.entry_count), 32'd0);
    strobe(5'd3); idle(3); strobe(5'd3); idle(20);
    check("t6_new_press", 32'(bus.entry_bcd), 32'h0003);

    // 'D' handling
    press(5'hF);
    press(5'd1); press(5'd2); press(5'd3);
    snap();
    press(5'hD);
`ifdef KEYPAD_BACKSPACE_EN
    check("t7_bs_entry", 32'(bus.entry_bcd), 32'h0012);
    check("t7_bs_count", 32'(bus.entry_count), 32'd2);
    check("t7_bs_nolv", 32'(n_lv - b_lv), 32'd0);
`else
    check("t7_d_letter", 32'(bus.letter), 32'd3);
    check("t7_d_lv", 32'(n_lv - b_lv), 32'd1);
    check("t7_d_entry", 32'(bus.entry_bcd), 32'h0123);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
